// File: rtl/output_port_unit.sv
// Output-port stage of a 5-port router: round-robin arbitration with packet-level
// locking, a show-ahead flit FIFO and the link-side valid/ready interface.
module output_port_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            requestIn,
    input  logic [4:0]            validIn,
    input  logic [DATA_WIDTH-1:0] dataIn0,
    input  logic [DATA_WIDTH-1:0] dataIn1,
    input  logic [DATA_WIDTH-1:0] dataIn2,
    input  logic [DATA_WIDTH-1:0] dataIn3,
    input  logic [DATA_WIDTH-1:0] dataIn4,
    input  logic                  readyIn,
    output logic [4:0]            grant,
    output logic                  ready,
    output logic                  available,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  validOut,
    output logic                  o_dbg_state
);
    // Handshakes: a flit enters on any rising edge with grant[i] && validIn[i] && ready,
    // and leaves on any rising edge with validOut && readyIn; neither side may retract.
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    state_t                r_state, w_next_state;
    logic [2:0]            r_owner, w_next_owner;
    logic [2:0]            r_rr, w_next_rr;
    logic [2:0]            w_pick;
    logic [4:0]            r_grant, w_next_grant;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_rd, r_wr;
    logic [PTR_W:0]        r_count;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic                  w_full, w_push, w_pop, w_last;

    function automatic logic [2:0] wrap5(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
    endfunction

    always_comb begin
        case (r_owner)
            3'd0:    w_owner_data = dataIn0;
            3'd1:    w_owner_data = dataIn1;
            3'd2:    w_owner_data = dataIn2;
            3'd3:    w_owner_data = dataIn3;
            3'd4:    w_owner_data = dataIn4;
            default: w_owner_data = '0;
        endcase
    end

    // Scan offsets high to low so the requester closest to the rr pointer wins.
    always_comb begin
        w_pick = '0;
        for (int k = 4; k >= 0; k--) begin
            if (requestIn[wrap5(r_rr, 3'(k))]) begin
                w_pick = wrap5(r_rr, 3'(k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_rr    <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_rr    <= w_next_rr;
            r_grant <= w_next_grant;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_rr    = r_rr;
        w_next_grant = r_grant;
        case (r_state)
            ST_IDLE: begin
                w_next_grant = '0;
                if ((requestIn != '0) && !w_full) begin
                    w_next_state = ST_LOCKED;
                    w_next_owner = w_pick;
                    w_next_grant = 5'b00001 << w_pick;
                end
            end
            ST_LOCKED: begin
                if (w_push && w_last) begin
                    w_next_state = ST_IDLE;
                    w_next_grant = '0;
                    w_next_rr    = wrap5(r_owner, 3'd1);
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Tail (2'b10) and single (2'b00) are exactly the types with bit 14 clear.
    always_comb begin
        w_full      = (r_count == CNT_FULL);
        ready       = !w_full;
        available   = (r_state == ST_IDLE) && !w_full;
        w_push      = (r_state == ST_LOCKED) && validIn[r_owner] && !w_full;
        w_last      = !w_owner_data[DATA_WIDTH-2];
        validOut    = (r_count != '0);
        w_pop       = validOut && readyIn;
        dataOut     = validOut ? r_mem[r_rd] : '0;
        grant       = r_grant;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_ONE;
            if (w_pop)  r_rd <= r_rd + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) r_mem[r_wr] <= w_owner_data;
    end
endmodule

// File: doc/output_port_unit.md
Name: output_port_unit

Overview:
- Output-side stage of the 5-port router, directly downstream of the per-input datapath.
- Collects the per-port data, valid and request lines from all 5 input datapaths for one output port.
- Arbitrates round-robin with packet-level locking, buffers accepted flits in a small FIFO and drives the port's link.
- Returns the grant, ready and available signals that feed the datapaths' outputGrant, outputReady and outputAvailable inputs.

Parameters:
- DATA_WIDTH, 16, flit width; bits [15:14] are the flit type (2'b11 head, 2'b01 body, 2'b10 tail, 2'b00 single-flit packet).
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk, input, 1, single clock, all logic on rising edge.
- reset, input, 1, synchronous, active-low reset.
- requestIn, input, 5, bit i = input datapath i requests this port.
- validIn, input, 5, bit i = flit on dataIn<i> is valid.
- dataIn0..dataIn4, input, 16 each, flit from input datapath 0..4.
- readyIn, input, 1, downstream link accepts the FIFO head this cycle.
- grant, output, 5, one-hot registered grant to the owning input, all zero when idle.
- ready, output, 1, FIFO can accept a flit this cycle.
- available, output, 1, port is unlocked and the FIFO is not full.
- dataOut, output, 16, FIFO head flit.
- validOut, output, 1, dataOut is valid.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, grant=0, rr pointer=0, FIFO count=0, rd/wr pointers=0.
  - dataOut=0, validOut=0, ready=1, available=1.
  - Reset mid-packet discards the lock and all FIFO contents; no partial flush.
- FSM states: IDLE, LOCKED.
- IDLE:
  - If requestIn!=0 and the FIFO is not full, choose the first requesting input scanning from the rr pointer upward, mod 5.
  - Next cycle: grant=onehot(owner), state=LOCKED.
  - Otherwise stay in IDLE with grant=0.
- LOCKED:
  - grant holds onehot(owner).
  - Push dataIn<owner> when validIn[owner] && ready.
  - validIn and requestIn from non-owners are ignored.
  - Deasserting requestIn[owner] does not release the lock; only a flit push releases it.
- Release:
  - Pushing a flit of type 2'b10 (tail) or 2'b00 (single) releases the lock.
  - Next cycle: state=IDLE, grant=0, rr pointer=(owner+1) mod 5.
  - Arbitration can re-grant at the earliest on the cycle after the release, so there is one idle cycle between packets.
- Ready and available:
  - ready = (count != DEPTH), combinational from registers.
  - When ready==0, the owner holds its flit; the unit never drops an accepted flit.
  - available = (state==IDLE) && (count != DEPTH).
- FIFO:
  - Show-ahead: dataOut = mem[rd_ptr], validOut = (count != 0).
  - dataOut reads 0 when the FIFO is empty.
  - Pop when validOut && readyIn.
  - Push and pop in the same cycle leave count unchanged.
  - Full: no push, even if a pop happens in the same cycle.
  - Empty: readyIn is ignored.
  - Pointers wrap modulo DEPTH.
- Latency: a flit pushed at edge N is on dataOut with validOut=1 after edge N (cycle N+1) if the FIFO was empty.
- Ordering: flits leave in acceptance order; packets are never interleaved.

Test Plan:
- Reset then single request:
  - Stimulus: reset low 1 cycle, requestIn=5'b00010, then head 16'hC880, body 16'h4001 and tail 16'h8002 on dataIn1 with validIn[1]=1, readyIn=1.
  - Required: grant=5'b00010 one cycle after the request; dataOut shows the 3 flits in order one cycle after each push; grant=0 the cycle after the tail push.
- Round-robin fairness:
  - Stimulus: requestIn=5'b10001 held, both inputs sending single-flit packets (type 2'b00).
  - Required: grants alternate 00001, 10000, 00001, with one idle cycle between each.
- Backpressure and full:
  - Stimulus: readyIn=0, owner streams 6 body flits.
  - Required: ready drops to 0 after 4 pushes, count stays at 4, flits 5 and 6 are held not lost. Then readyIn=1: all 6 flits emerge in order.
- Simultaneous push and pop at count 2: count stays 2, and data order is preserved across pointer wrap (at least 9 flits through a DEPTH-4 FIFO).
- Lock enforcement: a non-owner asserts validIn with data 16'hFFFF mid-packet; that flit never appears on dataOut, and the owner's packet completes intact.
- Reset mid-packet: after the head plus 1 body flit are pushed, pulse reset low. Required: validOut=0, grant=0 and available=1 next cycle; a new packet is then accepted from the rr pointer=0 scan.
